chunk_builder: RTL
==================

CHUNK_BUILDER -- requirements
Module: chunk_builder

Interface
REQ-001 The block SHALL take CHUNK_SIZE and INPUT_CELL_SIZE from the shared types package, not as module parameters; PIXELS_PER_CHUNK = CHUNK_SIZE*INPUT_CELL_SIZE*INPUT_CELL_SIZE.
REQ-002 Port list (clock and reset first), which SHALL be exactly:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- in_pixel  in  24  {R,G,B}, 8 bits each
- in_valid  in  1  in_pixel valid
- in_sof  in  1  start of frame; qualifies the pixel it accompanies
- in_ready  out  1  block accepts in_pixel this cycle
- last_chunk  out  chunk_input  previously presented chunk
- current_chunk  out  chunk_input  newest complete chunk
- out_first  out  1  current_chunk is the first chunk of a frame
- out_valid  out  1  chunk pair valid
- out_ready  in  1  processor consumes the chunk pair
- resync_count  out  8  saturating count of mid-chunk in_sof events

Function
REQ-003 An input pixel SHALL be accepted when in_valid && in_ready are high at a rising edge of clk.
REQ-004 Accepted pixels SHALL arrive in chunk order: column k fastest, then row j, then cell i. Each SHALL be written to fill buffer element [i][j][k].
REQ-005 Counters k, j, i SHALL wrap at INPUT_CELL_SIZE-1, INPUT_CELL_SIZE-1 and CHUNK_SIZE-1 respectively. The wrap of i marks the final pixel of the chunk.
REQ-006 Promotion: current_chunk <= fill buffer; last_chunk <= previous current_chunk, or all-zero if the chunk began with in_sof; out_first <= that in_sof flag; out_valid <= 1.
REQ-007 If the final pixel is accepted while (!out_valid || out_ready), promotion SHALL occur at that same edge, so out_valid is high in the next cycle (latency 1).
REQ-008 Otherwise the block SHALL set fill_complete and deassert in_ready. Promotion SHALL occur at the first edge where out_valid && out_ready, with no bubble.
REQ-009 in_ready SHALL equal !fill_complete (registered state only, no combinational path from out_ready).
REQ-010 out_valid SHALL clear at an edge with out_valid && out_ready unless a promotion occurs at that same edge.
REQ-011 last_chunk, current_chunk and out_first SHALL stay stable while out_valid && !out_ready.
REQ-012 States SHALL be:
- FILLING: in_ready=1
- FULL_WAIT: fill_complete=1, in_ready=0
- FILLING -> FULL_WAIT on final pixel accepted with out_valid && !out_ready
- FULL_WAIT -> FILLING on promotion
REQ-013 in_sof accepted at index 0 SHALL set the chunk's sof flag.
REQ-014 in_sof accepted at a nonzero index SHALL:
- discard the partial fill
- store the pixel at [0][0][0]
- set the sof flag
- increment resync_count, saturating at 255
REQ-015 in_sof on the final-pixel position with CHUNK_SIZE*INPUT_CELL_SIZE^2 > 1 SHALL be handled as REQ-014 (no promotion).
REQ-016 Pixels with in_valid low SHALL NOT advance counters; in_sof without in_valid SHALL be ignored.

Reset
REQ-017 rst high SHALL asynchronously clear: counters, fill_complete, sof flag, out_valid, out_first, resync_count, last_chunk, current_chunk (all zero); state = FILLING.
REQ-018 While rst is high, in_ready SHALL be 0. It SHALL be 1 in the first cycle after rst deasserts.
REQ-019 Reset mid-chunk or mid-handshake SHALL discard all partial and pending data, with no promotion after release.

Structure
REQ-020 pixel_t, chunk_input, CHUNK_SIZE and INPUT_CELL_SIZE SHALL live in the shared types package. PIXELS_PER_CHUNK and the state enum SHALL be added there.
REQ-021 One sub-module, chunk_index_counter (k/j/i counters with wrap, final and sync-clear outputs), is natural; the buffers and FSM stay in chunk_builder.

Verification (CHUNK_SIZE=4, INPUT_CELL_SIZE=2, 16 px/chunk)
REQ-022 Reset release -> in_ready=1, out_valid=0, resync_count=0, all chunk bits 0.
REQ-023 out_ready=1; in_sof with pixel 0, then pixels 0x000001..0x000010 back-to-back:
- out_valid=1 the cycle after pixel 16
- current_chunk[3][1][1]=0x000010
- last_chunk all zero, out_first=1
REQ-024 out_ready=0; stream 32 pixels:
- in_ready drops after pixel 32 is accepted
- first pair held stable
- raise out_ready -> second chunk presented next cycle, last_chunk = first chunk, out_first=0
REQ-025 in_sof asserted on pixel index 5:
- resync_count=1
- that pixel lands at [0][0][0]
- the next promotion follows 15 more pixels
REQ-026 Final pixel accepted in the same cycle out_valid && out_ready -> out_valid stays 1 and new data appears with no bubble.
REQ-027 rst pulsed mid-chunk (pixel 7) -> outputs zero; a fresh 16-pixel chunk is promoted normally with last_chunk zero.

Source files
------------

// File: rtl/chunk_builder_pkg.sv
// Shared types for the chunk builder: pixel and chunk shapes, derived sizes, FSM states.
// No logic; widths derive from CHUNK_SIZE and INPUT_CELL_SIZE.
// Import with chunk_builder_pkg::* in every file that touches chunk data.
package chunk_builder_pkg;

   localparam int CHUNK_SIZE       = 4;
   localparam int INPUT_CELL_SIZE  = 2;
   localparam int PIXELS_PER_CHUNK = CHUNK_SIZE * INPUT_CELL_SIZE * INPUT_CELL_SIZE;

   // Counter widths; at least one bit so a size of 1 still yields a legal vector.
   localparam int CELL_W  = (INPUT_CELL_SIZE > 1) ? $clog2(INPUT_CELL_SIZE) : 1;
   localparam int CHUNK_W = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;

   // {R,G,B}, 8 bits each.
   typedef logic [23:0] pixel_t;

   // Element [i][j][k] sits at flat position (i*S + j)*S + k, i.e. arrival order.
   typedef pixel_t [CHUNK_SIZE-1:0][INPUT_CELL_SIZE-1:0][INPUT_CELL_SIZE-1:0] chunk_input;

   typedef enum logic {
      FILLING   = 1'b0,
      FULL_WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/chunk_index_counter.sv
// Purpose: k/j/i write-position counters for the fill buffer (k fastest, then j, then i).
// Latency: new position visible the cycle after step/restart; at_zero/at_final are combinational.
// Backpressure: none; the caller only steps on accepted pixels.
module chunk_index_counter
   import chunk_builder_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               step,
   input  logic               restart,
   output logic [CELL_W-1:0]  k,
   output logic [CELL_W-1:0]  j,
   output logic [CHUNK_W-1:0] i,
   output logic               at_zero,
   output logic               at_final
);

   logic [CELL_W-1:0]  base_k, base_j, next_k, next_j;
   logic [CHUNK_W-1:0] base_i, next_i;
   logic               base_k_wrap, base_j_wrap, base_i_wrap;

   assign at_zero  = (k == '0) && (j == '0) && (i == '0);
   assign at_final = (k == CELL_W'(INPUT_CELL_SIZE - 1)) &&
                     (j == CELL_W'(INPUT_CELL_SIZE - 1)) &&
                     (i == CHUNK_W'(CHUNK_SIZE - 1));

   // Advance from the current position, or from zero on restart (the restart
   // pixel occupies position 0, so the counter lands on the slot after it).
   always_comb begin
      base_k      = restart ? '0 : k;
      base_j      = restart ? '0 : j;
      base_i      = restart ? '0 : i;
      base_k_wrap = (base_k == CELL_W'(INPUT_CELL_SIZE - 1));
      base_j_wrap = (base_j == CELL_W'(INPUT_CELL_SIZE - 1));
      base_i_wrap = (base_i == CHUNK_W'(CHUNK_SIZE - 1));
      next_k      = base_k_wrap ? '0 : base_k + CELL_W'(1);
      next_j      = base_j;
      next_i      = base_i;
      if (base_k_wrap) begin
         next_j = base_j_wrap ? '0 : base_j + CELL_W'(1);
         if (base_j_wrap) begin
            next_i = base_i_wrap ? '0 : base_i + CHUNK_W'(1);
         end
      end
   end

   // Position register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k <= '0;
         j <= '0;
         i <= '0;
      end else if (step || restart) begin
         k <= next_k;
         j <= next_j;
         i <= next_i;
      end
   end

endmodule

// File: rtl/chunk_builder.sv
// Purpose: assemble a pixel stream into chunks and present {last, current} chunk pairs.
// Latency: pair valid one cycle after the final pixel when the output slot is free.
// Backpressure: a finished chunk waiting on out_ready drops in_ready until it is promoted.
module chunk_builder
   import chunk_builder_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] in_pixel,
   input  logic        in_valid,
   input  logic        in_sof,
   output logic        in_ready,
   output chunk_input  last_chunk,
   output chunk_input  current_chunk,
   output logic        out_first,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  resync_count
);

   state_t             state_q, state_d;
   logic               fill_complete;
   chunk_input         fill_q, fill_d;
   logic               sof_q, sof_eff;
   logic               accept, resync, final_accept, promote;
   logic [CELL_W-1:0]  k, j;
   logic [CHUNK_W-1:0] i;
   logic               at_zero, at_final;

   assign fill_complete = (state_q == FULL_WAIT);
   // Held low during reset so nothing is taken while the block is being cleared.
   assign in_ready      = !fill_complete && !rst;
   assign accept        = in_valid && in_ready;
   // A frame start anywhere but position 0 throws away the partial chunk.
   assign resync        = accept && in_sof && !at_zero;
   assign final_accept  = accept && at_final && !resync;
   // Frame-start flag of the chunk being promoted; covers a one-pixel chunk
   // whose only pixel carries in_sof.
   assign sof_eff       = sof_q || (accept && in_sof && at_zero);
   assign promote       = (final_accept && (!out_valid || out_ready)) ||
                          (fill_complete && out_valid && out_ready);

   chunk_index_counter u_idx (
      .clk      (clk),
      .rst      (rst),
      .step     (accept && !resync),
      .restart  (resync),
      .k        (k),
      .j        (j),
      .i        (i),
      .at_zero  (at_zero),
      .at_final (at_final)
   );

   // Fill buffer contents including this cycle's write, so an immediate
   // promotion carries the final pixel.
   always_comb begin
      fill_d = fill_q;
      if (accept) begin
         if (resync) begin
            fill_d[0][0][0] = in_pixel;
         end else begin
            fill_d[i][j][k] = in_pixel;
         end
      end
   end

   // Next state: park in FULL_WAIT when a chunk completes behind an unconsumed pair.
   always_comb begin
      state_d = state_q;
      case (state_q)
         FILLING:   if (final_accept && out_valid && !out_ready) state_d = FULL_WAIT;
         FULL_WAIT: if (promote) state_d = FILLING;
         default:   state_d = FILLING;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= FILLING;
      else     state_q <= state_d;
   end

   // Fill buffer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) fill_q <= '0;
      else     fill_q <= fill_d;
   end

   // Frame-start flag of the chunk under construction; held through FULL_WAIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    sof_q <= 1'b0;
      else if (resync)            sof_q <= 1'b1;
      else if (accept && at_zero) sof_q <= in_sof;
   end

   // Output pair: promote on completion/handshake, otherwise drop valid once consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         current_chunk <= '0;
         last_chunk    <= '0;
         out_first     <= 1'b0;
         out_valid     <= 1'b0;
      end else if (promote) begin
         current_chunk <= fill_d;
         last_chunk    <= sof_eff ? '0 : current_chunk;
         out_first     <= sof_eff;
         out_valid     <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid     <= 1'b0;
      end
   end

   // Saturating count of mid-chunk frame starts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                resync_count <= '0;
      else if (resync && resync_count != '1) resync_count <= resync_count + 8'd1;
   end

endmodule
